// File: rtl/fpu_uart_pkg.sv
// rtl/fpu_uart_pkg.sv - shared types and defaults for the FPU UART byte paths
package fpu_uart_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } asm_state_t;

    // Shared with the transmit-side byte sequencer.
    localparam int DEFAULT_BYTES          = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - inter-byte gap counter with load-to-zero and expiry flag
module gap_timer
    import fpu_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] cnt;

    assign expired = (cnt == TW'(TIMEOUT_CYCLES - 1));

    // Saturates at the expiry value; the owner decides what expiry means.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + TW'(1);
        end
    end

endmodule

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - MSB-first byte-to-word assembler with gap timeout and overrun flag
module uart_word_assembler
    import fpu_uart_pkg::*;
#(
    parameter int BYTES          = DEFAULT_BYTES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rx_data,
    input  logic                      rx_done_tick,
    input  logic                      clear,
    output logic [8*BYTES-1:0]        word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [$clog2(BYTES)-1:0]  byte_count,
    output logic                      timeout_err,
    output logic                      overrun_err
);

    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES);

    asm_state_t      state, state_n;
    logic [W-1:0]    sh, sh_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            valid_n, to_n, ov_n;
    logic            capture;
    logic            tmr_load, tmr_run, tmr_expired;

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        to_n     = 1'b0;
        ov_n     = 1'b0;
        capture  = 1'b0;
        tmr_load = 1'b0;
        tmr_run  = 1'b0;

        if (clear) begin
            state_n  = IDLE;
            cnt_n    = '0;
            tmr_load = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_done_tick) begin
                        capture  = 1'b1;
                        cnt_n    = CW'(1);
                        state_n  = COLLECT;
                        tmr_load = 1'b1;
                    end
                end
                COLLECT: begin
                    // A byte arriving on the expiry cycle takes precedence.
                    if (rx_done_tick) begin
                        capture  = 1'b1;
                        tmr_load = 1'b1;
                        if (cnt == CW'(BYTES - 1)) begin
                            state_n = HOLD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else if (tmr_expired) begin
                        state_n  = IDLE;
                        cnt_n    = '0;
                        to_n     = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_run = 1'b1;
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        if (rx_done_tick) begin
                            capture  = 1'b1;
                            cnt_n    = CW'(1);
                            state_n  = COLLECT;
                            tmr_load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (rx_done_tick) begin
                        ov_n = 1'b1;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    tmr_load = 1'b1;
                end
            endcase
        end

        sh_n    = capture ? {sh[W-9:0], rx_data} : sh;
        valid_n = (state_n == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sh          <= '0;
            cnt         <= '0;
            word_valid  <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            sh          <= sh_n;
            cnt         <= cnt_n;
            word_valid  <= valid_n;
            timeout_err <= to_n;
            overrun_err <= ov_n;
        end
    end

    assign word_out   = sh;
    assign byte_count = cnt;

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - directed self-checking bench for uart_word_assembler
module tb_uart_word_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done_tick = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [2:0]  byte_count;
    logic        timeout_err;
    logic        overrun_err;

    int total = 0;
    int bad   = 0;

    int to_cnt = 0;
    int ov_cnt = 0;
    int vld_cnt = 0;
    int acc_cnt = 0;
    logic [63:0] acc_words [0:63];

    uart_word_assembler #(
        .BYTES(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .clear        (clear),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .byte_count   (byte_count),
        .timeout_err  (timeout_err),
        .overrun_err  (overrun_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout_err) to_cnt <= to_cnt + 1;
        if (overrun_err) ov_cnt <= ov_cnt + 1;
        if (word_valid) vld_cnt <= vld_cnt + 1;
        if (word_valid && word_ready) begin
            acc_words[acc_cnt[5:0]] <= word_out;
            acc_cnt <= acc_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        step();
        rx_done_tick = 1'b0;
    endtask

    initial begin
        int base_to, base_ov, base_vld, base_acc, seen_at;
        logic [7:0] pi_bytes [0:7];
        pi_bytes = '{8'h40, 8'h09, 8'h21, 8'hFB, 8'h54, 8'h44, 8'h2D, 8'h18};

        // Reset state
        #12;
        check("rst_word_out",   word_out, 64'd0);
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_byte_count", 64'(byte_count), 64'd0);
        check("rst_errors",     64'({timeout_err, overrun_err}), 64'd0);
        #4 rst = 1'b1;
        step();

        // Full word with 3-cycle spacing
        word_ready = 1'b1;
        base_to = to_cnt; base_ov = ov_cnt; base_vld = vld_cnt;
        for (int i = 0; i < 7; i++) begin
            send(pi_bytes[i]);
            idle(2);
        end
        check("pi_count7", 64'(byte_count), 64'd7);
        send(pi_bytes[7]);
        check("pi_valid", 64'(word_valid), 64'd1);
        check("pi_word", word_out, 64'h400921FB54442D18);
        step();
        check("pi_valid_drop", 64'(word_valid), 64'd0);
        idle(2);
        check("pi_valid_cycles", 64'(vld_cnt - base_vld), 64'd1);
        check("pi_no_errors", 64'((to_cnt - base_to) + (ov_cnt - base_ov)), 64'd0);

        // Back-to-back ticks across the HOLD/capture overlap
        base_acc = acc_cnt; base_ov = ov_cnt;
        for (int i = 0; i < 16; i++) send(8'(i));
        step();
        idle(2);
        check("b2b_words", 64'(acc_cnt - base_acc), 64'd2);
        check("b2b_word0", acc_words[base_acc[5:0]], 64'h0001020304050607);
        check("b2b_word1", acc_words[6'(base_acc + 1)], 64'h08090A0B0C0D0E0F);
        check("b2b_no_overrun", 64'(ov_cnt - base_ov), 64'd0);

        // Gap timeout
        base_to = to_cnt;
        send(8'hC1); send(8'hC2); send(8'hC3);
        seen_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (timeout_err && seen_at < 0) seen_at = k;
        end
        check("to_latency", 64'(seen_at), 64'd16);
        check("to_pulses", 64'(to_cnt - base_to), 64'd1);
        check("to_count", 64'(byte_count), 64'd0);
        for (int i = 0; i < 8; i++) send(8'h11 * 8'(i + 1));
        check("to_next_word", word_out, 64'h1122334455667788);
        check("to_next_valid", 64'(word_valid), 64'd1);
        idle(2);

        // Byte on the exact expiry cycle wins
        base_to = to_cnt;
        send(8'hA0); send(8'hA1);
        idle(15);
        send(8'hA2);
        check("race_count", 64'(byte_count), 64'd3);
        step();
        check("race_no_timeout", 64'(to_cnt - base_to), 64'd0);
        for (int i = 3; i < 8; i++) send(8'hA0 + 8'(i));
        check("race_word", word_out, 64'hA0A1A2A3A4A5A6A7);
        idle(2);

        // Overrun while held, then accept-and-capture in one cycle
        word_ready = 1'b0;
        base_ov = ov_cnt;
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle(2);
        send(8'hAA);
        check("ov_pulse", 64'(overrun_err), 64'd1);
        check("ov_word_kept", word_out, 64'h0102030405060708);
        check("ov_valid_kept", 64'(word_valid), 64'd1);
        word_ready = 1'b1;
        send(8'h55);
        check("ov_accept_count", 64'(byte_count), 64'd1);
        check("ov_accept_valid", 64'(word_valid), 64'd0);
        check("ov_single_pulse", 64'(ov_cnt - base_ov), 64'd1);
        for (int i = 1; i < 8; i++) send(8'h55 + 8'(i));
        check("ov_next_word", word_out, 64'h55565758595A5B5C);
        idle(2);

        // Clear mid-word, with a tick in the same cycle
        base_to = to_cnt; base_ov = ov_cnt;
        for (int i = 0; i < 5; i++) send(8'hE0 + 8'(i));
        clear = 1'b1;
        send(8'hEE);
        clear = 1'b0;
        check("clr_count", 64'(byte_count), 64'd0);
        check("clr_valid", 64'(word_valid), 64'd0);
        idle(20);
        check("clr_no_pulses", 64'((to_cnt - base_to) + (ov_cnt - base_ov)), 64'd0);

        // Asynchronous reset mid-word
        send(8'h91); send(8'h92); send(8'h93);
        #2 rst = 1'b0;
        #1;
        check("arst_word_out", word_out, 64'd0);
        check("arst_count", 64'(byte_count), 64'd0);
        check("arst_flags", 64'({word_valid, timeout_err, overrun_err}), 64'd0);
        step();
        #3 rst = 1'b1;
        step();
        for (int i = 0; i < 8; i++) send(8'h70 + 8'(i));
        check("arst_next_word", word_out, 64'h7071727374757677);
        check("arst_next_valid", 64'(word_valid), 64'd1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
